ioctl_rom_router: RTL and testbench
===================================

# ioctl_rom_router

Parametrised download router between the HPS `ioctl` stream and the core's load targets: ROM regions, the DIP-switch bank and the per-game mod byte. It generalises the fixed index-0 ROM write, the index-1 mod byte and the index-254 DIP capture into one block. It adds N address-decoded ROM regions with rebased addresses, per-region back-pressure through `ioctl_wait`, and a download-complete pulse. It sits directly after `hps_io` in `emu`, clocked by `clk_sys`.

## Interface
Parameters:
- `NREG`, 4: number of ROM regions.
- `AW`, 25: ioctl/ROM address width.
- `REG_BASE`, {0,'h4000,'h8000,'hC000}: packed `NREG*AW` region start addresses, ascending; region i spans [base_i, base_i+1).
- `ROM_END`, 'h10000: exclusive end of the last region.
- `ROM_INDEX`, 0; `MOD_INDEX`, 1; `DIP_INDEX`, 254: ioctl_index selectors.
- `DIP_BYTES`, 8: DIP bank depth.

Ports:
- `clk_sys` in 1: system clock.
- `RESET_n` in 1: asynchronous active-low reset.
- `ioctl_download` in 1: download active.
- `ioctl_wr` in 1: byte strobe.
- `ioctl_addr` in AW: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_index` in 8: stream index.
- `ioctl_wait` out 1: stall request to HPS.
- `rom_wr` out NREG: one-hot region write request.
- `rom_ready` in NREG: region accepts the write this cycle.
- `rom_addr` out AW: address rebased to the region start.
- `rom_data` out 8: write data.
- `dip_sw` out DIP_BYTES*8: DIP bank, byte k at [8k+7:8k].
- `mod_byte` out 8: game mod byte.
- `mod_valid` out 1: mod byte written since reset.
- `dl_done` out 1: one-cycle pulse when a ROM download has fully drained.
- `err_drop` out 1: sticky; a write was dropped (out of range, or overrun while holding).

## Operation
- **Reset.** Every output is 0: `dip_sw`, `mod_byte`, `mod_valid`, `rom_wr`, `rom_addr`, `rom_data`, `ioctl_wait`, `dl_done` and `err_drop`. The hold register is empty and the FSM is in IDLE. Reset asserted mid-download aborts the pending write; it is not completed.
- **FSM states and transitions:**
  - IDLE → LOAD on `ioctl_download` with index `ROM_INDEX`.
  - LOAD → DRAIN on falling `ioctl_download`.
  - DRAIN → DONE once the hold register is empty.
  - DONE → IDLE after one cycle, with `dl_done`=1 in DONE.
- **ROM writes.** Decode applies when `ioctl_wr` is high and index = `ROM_INDEX`.
  - The selected region is the highest i with addr ≥ base_i, provided addr < `ROM_END`.
  - The hold register captures region, addr−base_i and data.
  - If addr ≥ `ROM_END`: the write is dropped, `err_drop` is set, and nothing is held.
- **Hold / handshake.**
  - While the hold register is valid, `rom_wr[sel]`=1 and `rom_addr`/`rom_data` stay stable.
  - Acceptance occurs when `rom_wr[sel] & rom_ready[sel]`; the hold clears at that edge.
  - `ioctl_wait` = hold valid & ~accept (combinational).
  - If a new ROM `ioctl_wr` arrives while holding and not accepting, it is dropped, `err_drop` is set, and the held write is preserved.
  - If a new write arrives on the same cycle as acceptance, the new write loads (back-to-back).
- **DIP.** When index = `DIP_INDEX` and addr < `DIP_BYTES`, `dip_sw` byte[addr] is written at the next edge. Addresses ≥ `DIP_BYTES` are ignored silently. DIP writes do not use the hold register and do not stall.
- **MOD.** When index = `MOD_INDEX` and addr = 0, `mod_byte` is written and `mod_valid` is set.
- **Other indices** are ignored.
- **Width rules.** Rebasing is AW-bit unsigned subtraction; it cannot underflow because of the decode order.

## Timing
- `ioctl_wr` at edge N: the hold register is valid and `rom_wr` is high in cycle N+1. With `rom_ready`=1, the write is accepted at edge N+1, so the minimum latency is 1 cycle.
- `rom_wr` stays high until accepted; there is no timeout.
- A DIP or mod byte is visible on its output in cycle N+1.
- `dl_done` asserts exactly 1 cycle after the edge at which DRAIN sees the hold register empty. If the download ends with the hold register already empty, the sequence is fall → DRAIN (1 cycle) → DONE (1 cycle).
- `err_drop` clears only on reset.

## Structure
- A shared package `ioctl_pkg` holds:
  - the state enum (IDLE/LOAD/DRAIN/DONE);
  - index localparams;
  - a `hold_t` struct {valid, sel[$clog2(NREG)], addr, data}.
- One natural sub-module, `ioctl_region_decode`: purely combinational addr → {hit, sel, rebased addr} using `REG_BASE`/`ROM_END`.

## Test plan
- **Reset and DIP.** Reset, then write index 254 at addr 3 with data 'h5A → `dip_sw[31:24]`='h5A next cycle and all other bytes 0. Write at addr 9 → no change and `err_drop`=0.
- **Region decode and rebase.** Default bases: write addr 'h8005 with data 'hC3 and all ready → `rom_wr`=4'b0100, `rom_addr`='h0005, `rom_data`='hC3 for one cycle.
- **Back-pressure.** Hold `rom_ready[1]`=0 for 5 cycles after writing addr 'h4000:
  - `ioctl_wait`=1 and `rom_wr[1]` stable for 5 cycles;
  - raise ready → accepted, `ioctl_wait`=0 in that same cycle.
- **Overrun and out-of-range.** A second ROM write during the stall → `err_drop`=1 and the held data is unchanged. Separately, addr 'h10000 → `err_drop`=1 and no `rom_wr`.
- **Completion and reset.**
  - Drop `ioctl_download` with a write still held → `dl_done` pulses only after acceptance, exactly once.
  - Assert `RESET_n`=0 mid-hold → all outputs 0 immediately, and no write is issued after release.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl download router.
package ioctl_pkg;

    // Download sequencing states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Default ioctl_index selectors.
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Hold register geometry; sized for the default 4-region, 25-bit layout.
    localparam int unsigned HOLD_SEL_W = 2;
    localparam int unsigned HOLD_AW    = 25;

    typedef struct packed {
        logic                  valid;
        logic [HOLD_SEL_W-1:0] sel;
        logic [HOLD_AW-1:0]    addr;
        logic [7:0]            data;
    } hold_t;

endpackage

// File: rtl/ioctl_region_decode.sv
// Combinational address decode: byte address -> {hit, region, region-relative address}.
module ioctl_region_decode #(
    parameter int unsigned        NREG     = 4,
    parameter int unsigned        AW       = 25,
    parameter int unsigned        SW       = (NREG > 1) ? $clog2(NREG) : 1,
    parameter logic [NREG*AW-1:0] REG_BASE = {25'h0C000, 25'h08000, 25'h04000, 25'h00000},
    parameter logic [AW-1:0]      ROM_END  = 25'h10000
) (
    input  logic [AW-1:0] i_addr,
    output logic          o_hit,
    output logic [SW-1:0] o_sel,
    output logic [AW-1:0] o_rebased
);

    logic w_any;

    // Bases are ascending, so the last base not above the address wins.
    always_comb begin
        w_any     = 1'b0;
        o_sel     = '0;
        o_rebased = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (i_addr >= REG_BASE[i*AW +: AW]) begin
                w_any     = 1'b1;
                o_sel     = SW'(i);
                o_rebased = i_addr - REG_BASE[i*AW +: AW];
            end
        end
        o_hit = w_any && (i_addr < ROM_END);
    end

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes the HPS ioctl byte stream to ROM regions (with back-pressure), the DIP bank
// and the mod byte, and pulses dl_done when a ROM download has fully drained.
module ioctl_rom_router
    import ioctl_pkg::*;
#(
    parameter int unsigned        NREG      = 4,
    parameter int unsigned        AW        = HOLD_AW,
    parameter logic [NREG*AW-1:0] REG_BASE  = {25'h0C000, 25'h08000, 25'h04000, 25'h00000},
    parameter logic [AW-1:0]      ROM_END   = 25'h10000,
    parameter logic [7:0]         ROM_INDEX = IDX_ROM,
    parameter logic [7:0]         MOD_INDEX = IDX_MOD,
    parameter logic [7:0]         DIP_INDEX = IDX_DIP,
    parameter int unsigned        DIP_BYTES = 8
) (
    input  logic                   clk_sys,
    input  logic                   RESET_n,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [AW-1:0]          ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    input  logic [7:0]             ioctl_index,
    output logic                   ioctl_wait,
    output logic [NREG-1:0]        rom_wr,
    input  logic [NREG-1:0]        rom_ready,
    output logic [AW-1:0]          rom_addr,
    output logic [7:0]             rom_data,
    output logic [DIP_BYTES*8-1:0] dip_sw,
    output logic [7:0]             mod_byte,
    output logic                   mod_valid,
    output logic                   dl_done,
    output logic                   err_drop
);

    localparam int unsigned SW = (NREG > 1) ? $clog2(NREG) : 1;

    hold_t                  r_hold;
    state_e                 r_state;
    state_e                 w_state_d;
    logic [DIP_BYTES*8-1:0] r_dip;
    logic [7:0]             r_mod;
    logic                   r_mod_valid;
    logic                   r_err;

    logic                   w_hit;
    logic [SW-1:0]          w_sel;
    logic [AW-1:0]          w_rebased;
    logic [SW-1:0]          w_held_sel;
    logic                   w_rom_req;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_drop;
    logic                   w_dip_we;
    logic                   w_mod_we;

    ioctl_region_decode #(
        .NREG     (NREG),
        .AW       (AW),
        .SW       (SW),
        .REG_BASE (REG_BASE),
        .ROM_END  (ROM_END)
    ) u_decode (
        .i_addr    (ioctl_addr),
        .o_hit     (w_hit),
        .o_sel     (w_sel),
        .o_rebased (w_rebased)
    );

    assign w_held_sel = SW'(r_hold.sel);
    assign w_rom_req  = ioctl_wr && (ioctl_index == ROM_INDEX);
    assign w_accept   = r_hold.valid && rom_ready[w_held_sel];
    // A slot frees up in the same cycle it is accepted, allowing back-to-back writes.
    assign w_load     = w_rom_req && w_hit && (!r_hold.valid || w_accept);
    assign w_drop     = w_rom_req && (!w_hit || (r_hold.valid && !w_accept));
    assign w_dip_we   = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr < AW'(DIP_BYTES));
    assign w_mod_we   = ioctl_wr && (ioctl_index == MOD_INDEX) && (ioctl_addr == '0);
    assign ioctl_wait = r_hold.valid && !w_accept;

    // Hold register: load a decoded ROM write, clear it on acceptance.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_hold <= '0;
        end else if (w_load) begin
            r_hold.valid <= 1'b1;
            r_hold.sel   <= HOLD_SEL_W'(w_sel);
            r_hold.addr  <= HOLD_AW'(w_rebased);
            r_hold.data  <= ioctl_dout;
        end else if (w_accept) begin
            r_hold.valid <= 1'b0;
        end
    end

    // Sticky drop flag, DIP bank and mod byte capture.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_err       <= 1'b0;
            r_dip       <= '0;
            r_mod       <= '0;
            r_mod_valid <= 1'b0;
        end else begin
            if (w_drop) begin
                r_err <= 1'b1;
            end
            for (int unsigned k = 0; k < DIP_BYTES; k++) begin
                if (w_dip_we && (ioctl_addr == AW'(k))) begin
                    r_dip[k*8 +: 8] <= ioctl_dout;
                end
            end
            if (w_mod_we) begin
                r_mod       <= ioctl_dout;
                r_mod_valid <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next state and the completion pulse.
    always_comb begin
        w_state_d = r_state;
        dl_done   = 1'b0;
        unique case (r_state)
            StIdle:  if (ioctl_download && (ioctl_index == ROM_INDEX)) w_state_d = StLoad;
            StLoad:  if (!ioctl_download) w_state_d = StDrain;
            StDrain: if (!r_hold.valid) w_state_d = StDone;
            StDone: begin
                dl_done   = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // ROM request outputs are driven only while a write is held.
    always_comb begin
        rom_wr   = '0;
        rom_addr = '0;
        rom_data = '0;
        if (r_hold.valid) begin
            rom_wr[w_held_sel] = 1'b1;
            rom_addr           = AW'(r_hold.addr);
            rom_data           = r_hold.data;
        end
    end

    assign dip_sw    = r_dip;
    assign mod_byte  = r_mod;
    assign mod_valid = r_mod_valid;
    assign err_drop  = r_err;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Self-checking bench for ioctl_rom_router: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_ioctl_rom_router;

    logic        clk_sys = 1'b0;
    logic        RESET_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic [3:0]  rom_wr;
    logic [3:0]  rom_ready;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [63:0] dip_sw;
    logic [7:0]  mod_byte;
    logic        mod_valid;
    logic        dl_done;
    logic        err_drop;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    ioctl_rom_router dut (
        .clk_sys        (clk_sys),
        .RESET_n        (RESET_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .rom_wr         (rom_wr),
        .rom_ready      (rom_ready),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .dip_sw         (dip_sw),
        .mod_byte       (mod_byte),
        .mod_valid      (mod_valid),
        .dl_done        (dl_done),
        .err_drop       (err_drop)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- behavioural model ----------------
    int unsigned base_tbl [4] = '{32'h0, 32'h4000, 32'h8000, 32'hC000};
    localparam int unsigned RomEnd = 32'h10000;

    bit          m_valid;
    int unsigned m_sel;
    int unsigned m_addr;
    logic [7:0]  m_data;
    logic [7:0]  m_dip [8];
    logic [7:0]  m_mod;
    bit          m_modv;
    bit          m_err;
    int          m_phase; // 0 idle, 1 loading, 2 draining, 3 done

    task automatic model_reset();
        m_valid = 1'b0;
        m_sel   = 0;
        m_addr  = 0;
        m_data  = 8'h00;
        for (int k = 0; k < 8; k++) m_dip[k] = 8'h00;
        m_mod   = 8'h00;
        m_modv  = 1'b0;
        m_err   = 1'b0;
        m_phase = 0;
    endtask

    task automatic model_step();
        bit          acc;
        bit          was_valid;
        bit          loaded;
        int unsigned a;
        int unsigned region;
        acc       = m_valid && rom_ready[m_sel];
        was_valid = m_valid;
        loaded    = 1'b0;
        a         = 32'(ioctl_addr);
        if (ioctl_wr && ioctl_index == 8'd0) begin
            if (a >= RomEnd) m_err = 1'b1;
            else if (m_valid && !acc) m_err = 1'b1;
            else begin
                region = 0;
                for (int i = 0; i < 4; i++) if (a >= base_tbl[i]) region = i;
                m_sel  = region;
                m_addr = a - base_tbl[region];
                m_data = ioctl_dout;
                loaded = 1'b1;
            end
        end
        if (loaded) m_valid = 1'b1;
        else if (acc) m_valid = 1'b0;
        if (ioctl_wr && ioctl_index == 8'd254 && a < 8) m_dip[a] = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd1 && a == 0) begin
            m_mod  = ioctl_dout;
            m_modv = 1'b1;
        end
        case (m_phase)
            0: if (ioctl_download && ioctl_index == 8'd0) m_phase = 1;
            1: if (!ioctl_download) m_phase = 2;
            2: if (!was_valid) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask

    always @(posedge clk_sys) begin
        if (!RESET_n) model_reset();
        else model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the active edge.
    always @(negedge clk_sys) begin
        logic [3:0]  e_wr;
        logic [63:0] e_dip;
        if (chk_on) begin
            e_wr = m_valid ? 4'(1 << m_sel) : 4'd0;
            for (int k = 0; k < 8; k++) e_dip[k*8 +: 8] = m_dip[k];
            chk("m_rom_wr", 64'(rom_wr), 64'(e_wr));
            chk("m_rom_addr", 64'(rom_addr), m_valid ? 64'(m_addr) : 64'd0);
            chk("m_rom_data", 64'(rom_data), m_valid ? 64'(m_data) : 64'd0);
            chk("m_wait", 64'(ioctl_wait), 64'(m_valid && !rom_ready[m_sel]));
            chk("m_dip", dip_sw, e_dip);
            chk("m_mod", 64'(mod_byte), 64'(m_mod));
            chk("m_modv", 64'(mod_valid), 64'(m_modv));
            chk("m_err", 64'(err_drop), 64'(m_err));
            chk("m_done", 64'(dl_done), 64'(m_phase == 3));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Present one write strobe for one edge; returns 1 time unit after that edge.
    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        model_reset();
        tick();
        tick();
        RESET_n = 1'b1;
    endtask

    int          n_early;
    int          n_late;
    logic [24:0] boundary [9] = '{25'h0, 25'h3FFF, 25'h4000, 25'h7FFF, 25'h8000,
                                  25'hBFFF, 25'hC000, 25'hFFFF, 25'h10000};

    initial begin
        RESET_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        rom_ready      = 4'hF;
        model_reset();
        chk_on = 1'b1;
        tick();
        #1;
        chk("reset_outs", 64'({rom_wr, rom_addr, rom_data, ioctl_wait, dl_done, err_drop,
                               mod_valid, mod_byte}), 64'd0);
        chk("reset_dip", dip_sw, 64'd0);
        tick();
        RESET_n = 1'b1;

        // DIP capture and out-of-range DIP address
        wr_byte(8'd254, 25'd3, 8'h5A);
        #1;
        chk("dip_byte3", 64'(dip_sw[31:24]), 64'h5A);
        chk("dip_others", dip_sw, 64'h0000_0000_5A00_0000);
        wr_byte(8'd254, 25'd9, 8'h11);
        #1;
        chk("dip_addr9", dip_sw, 64'h0000_0000_5A00_0000);
        chk("dip_addr9_err", 64'(err_drop), 64'd0);

        // Mod byte; nonzero address ignored
        wr_byte(8'd1, 25'd0, 8'h3C);
        wr_byte(8'd1, 25'd1, 8'hFF);
        #1;
        chk("mod_byte", 64'(mod_byte), 64'h3C);
        chk("mod_valid", 64'(mod_valid), 64'd1);

        // Region decode and rebase
        rom_ready = 4'hF;
        wr_byte(8'd0, 25'h8005, 8'hC3);
        #1;
        chk("dec_wr", 64'(rom_wr), 64'b0100);
        chk("dec_addr", 64'(rom_addr), 64'h5);
        chk("dec_data", 64'(rom_data), 64'hC3);
        tick();
        #1;
        chk("dec_wr_gone", 64'(rom_wr), 64'd0);

        // Back-pressure on region 1 with an overrun during the stall
        rom_ready = 4'b1101;
        wr_byte(8'd0, 25'h4000, 8'h77);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_wait", 64'(ioctl_wait), 64'd1);
            chk("bp_wr", 64'(rom_wr), 64'b0010);
            chk("bp_data", 64'(rom_data), 64'h77);
            chk("bp_addr", 64'(rom_addr), 64'h0);
            if (i >= 2) chk("ovr_err", 64'(err_drop), 64'd1);
            if (i == 1) begin
                ioctl_wr    = 1'b1;
                ioctl_index = 8'd0;
                ioctl_addr  = 25'h4001;
                ioctl_dout  = 8'hEE;
            end
            tick();
            ioctl_wr = 1'b0;
        end
        rom_ready = 4'hF;
        #1;
        chk("bp_release_wait", 64'(ioctl_wait), 64'd0);
        chk("bp_release_wr", 64'(rom_wr), 64'b0010);
        tick();
        #1;
        chk("bp_after_wr", 64'(rom_wr), 64'd0);

        // Out-of-range address
        do_reset();
        wr_byte(8'd0, 25'h10000, 8'h99);
        #1;
        chk("oor_err", 64'(err_drop), 64'd1);
        chk("oor_wr", 64'(rom_wr), 64'd0);

        // Completion: dl_done only after the held write drains, exactly once
        do_reset();
        rom_ready      = 4'h0;
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        tick();
        wr_byte(8'd0, 25'h0100, 8'h42);
        ioctl_download = 1'b0;
        n_early = 0;
        n_late  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            n_early += int'(dl_done);
        end
        rom_ready = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            n_late += int'(dl_done);
        end
        chk("done_early", 64'(n_early), 64'd0);
        chk("done_once", 64'(n_late), 64'd1);

        // Reset during a held write
        rom_ready = 4'h0;
        wr_byte(8'd0, 25'h0004, 8'h55);
        #1;
        chk("rst_hold_wr", 64'(rom_wr), 64'b0001);
        RESET_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_outs", 64'({rom_wr, rom_addr, rom_data, ioctl_wait, dl_done, err_drop,
                                 mod_valid, mod_byte}), 64'd0);
        chk("rst_mid_dip", dip_sw, 64'd0);
        tick();
        tick();
        RESET_n   = 1'b1;
        rom_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("rst_no_wr", 64'(rom_wr), 64'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (n == 1500) do_reset();
            rom_ready = 4'(($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom));
            ioctl_wr  = 1'($urandom);
            if ($urandom_range(0, 39) == 0) ioctl_download = ~ioctl_download;
            r = int'($urandom_range(0, 9));
            ioctl_index = (r <= 5) ? 8'd0 : (r == 6) ? 8'd1 : (r == 7) ? 8'd254 :
                          (r == 8) ? 8'd7 : 8'd1;
            if (ioctl_index == 8'd0) begin
                if ($urandom_range(0, 2) == 0)
                    ioctl_addr = boundary[$urandom_range(0, 8)];
                else
                    ioctl_addr = 25'($urandom_range(0, 32'h10100));
            end else begin
                ioctl_addr = 25'($urandom_range(0, 11));
            end
            ioctl_dout = 8'($urandom);
            tick();
        end
        ioctl_wr = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
